// File: rtl/fifo_producer.sv
// Producer-side traffic source for the async FIFO write port: emits an incrementing
// data pattern in BURST_LEN-write bursts separated by IDLE_CYCLES idle cycles.
module fifo_producer #(
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 16,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  PROD_CLK,
  input  logic                  RST_N,
  input  logic                  I_ENABLE,
  input  logic                  I_FULL,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_WR_EN,
  output logic                  O_BUSY,
  output logic [CNT_WIDTH-1:0]  O_WORD_CNT
);

  // Counter widths are clamped to 1 so BURST_LEN=1 / IDLE_CYCLES<=1 still elaborate.
  localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GAP_W   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  wr_en;

  // Full gates the write enable with no register in the path.
  assign wr_en = (state_q == WRITE) && !I_FULL;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (I_ENABLE) state_d = WRITE;
      end
      WRITE: begin
        if (wr_en) begin
          data_d = data_q + DATA_WIDTH'(1);
          cnt_d  = cnt_q + CNT_WIDTH'(1);
          if (burst_q == BURST_LAST) begin
            burst_d = '0;
            if (IDLE_CYCLES > 0) state_d = GAP;
            else                 state_d = I_ENABLE ? WRITE : IDLE;
          end else begin
            burst_d = burst_q + BURST_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = I_ENABLE ? WRITE : IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PROD_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

  assign O_DATA     = data_q;
  assign O_WR_EN    = wr_en;
  assign O_BUSY     = (state_q != IDLE);
  assign O_WORD_CNT = cnt_q;

endmodule

// File: doc/fifo_producer.md
# fifo_producer

Producer-side traffic source for the asynchronous FIFO. It runs in the producer clock domain and drives write data and write enable into the FIFO write port. It obeys the FIFO full flag and emits an incrementing data pattern in fixed-length bursts separated by idle gaps. It is the upstream stage of the crossing-clock-domain path, and its outputs connect directly to the FIFO write side of the CCD interface.

## Interface
- DATA_WIDTH, 8: width of write data word
- BURST_LEN, 16: accepted writes per burst (≥1)
- IDLE_CYCLES, 4: gap cycles between bursts (≥0)
- CNT_WIDTH, 16: width of total-write counter
- PROD_CLK  input  1  producer clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- I_ENABLE  input  1  level; while high, producer issues bursts
- I_FULL  input  1  FIFO full flag, synchronous to PROD_CLK
- O_DATA  output  DATA_WIDTH  write data word presented to FIFO
- O_WR_EN  output  1  write enable; a write occurs on each rising edge with O_WR_EN=1
- O_BUSY  output  1  high whenever FSM is not IDLE
- O_WORD_CNT  output  CNT_WIDTH  total accepted writes since reset

## Operation
- FSM states: IDLE, WRITE, GAP.
- IDLE: I_ENABLE=1 → WRITE. Otherwise remain in IDLE.
- WRITE: O_WR_EN = !I_FULL (combinational). Each accepted write (O_WR_EN=1 at edge) does the following:
  - O_DATA increments by 1 mod 2^DATA_WIDTH.
  - O_WORD_CNT increments by 1 mod 2^CNT_WIDTH.
  - Burst counter increments.
- WRITE exit: on the accepted write where burst count = BURST_LEN-1, the burst counter clears. Next state:
  - GAP if IDLE_CYCLES>0.
  - Otherwise WRITE if I_ENABLE=1, IDLE if I_ENABLE=0.
- GAP: O_WR_EN=0 and the gap counter counts IDLE_CYCLES cycles. After the last gap cycle: WRITE if I_ENABLE=1, else IDLE.
- I_ENABLE deassert inside WRITE does not abort the burst. The burst completes all BURST_LEN accepted writes and then stops.
- I_FULL=1 stalls WRITE. O_WR_EN=0, and O_DATA, O_WORD_CNT and the burst counter hold. No write is ever issued while I_FULL=1.
- O_DATA persists across bursts and IDLE; it is not reset by re-enable. The first word after reset is 0.
- O_BUSY = (state != IDLE).

## Timing
- Reset (RST_N=0, asynchronous, takes effect immediately without a clock edge):
  - state=IDLE, O_DATA=0, O_WR_EN=0, O_BUSY=0, O_WORD_CNT=0.
  - Burst and gap counters = 0.
- Reset release: the first edge with RST_N=1 samples I_ENABLE.
- Start latency: I_ENABLE high at edge k in IDLE → O_BUSY=1 and O_WR_EN=!I_FULL during cycle k+1. The first write lands at edge k+1.
- Full response: zero cycles. O_WR_EN follows I_FULL combinationally within WRITE.
- Steady state with I_FULL=0: BURST_LEN consecutive write cycles, then IDLE_CYCLES cycles with O_WR_EN=0. Period = BURST_LEN+IDLE_CYCLES cycles.
- Reset asserted mid-burst: outputs clear immediately. A partially completed burst is abandoned, with no resume.

## Test plan
- Basic burst: BURST_LEN=4, IDLE_CYCLES=2, I_ENABLE held high, I_FULL=0.
  - Required: O_WR_EN pattern 1,1,1,1,0,0,1,1,1,1.
  - Data 0,1,2,3 then 4,5,6,7.
  - O_WORD_CNT=8 after the 8th write.
- Full stall: assert I_FULL for 3 cycles after the 2nd write of a burst.
  - Required: O_WR_EN=0 for those 3 cycles and O_DATA holds at 2.
  - Burst resumes with 2,3 and still totals 4 writes.
- Enable drop: deassert I_ENABLE after the 1st write of a burst.
  - Required: the remaining 3 writes complete, then the gap, then IDLE.
  - O_BUSY=0 after the gap; no further writes.
- Wrap-around: DATA_WIDTH=8 with 260 writes.
  - Required: O_DATA sequence ...,254,255,0,1,2,3.
  - O_WORD_CNT=260.
- Reset mid-burst: pull RST_N low between clock edges during WRITE.
  - Required: O_WR_EN, O_DATA, O_BUSY and O_WORD_CNT all 0 before the next edge.
  - After release with I_ENABLE=1, the first written word = 0.
- Zero gap: IDLE_CYCLES=0, BURST_LEN=3, I_FULL=0.
  - Required: continuous O_WR_EN=1 across burst boundaries.
  - Data 0..5 on six consecutive edges.
